// File: rtl/nasti_dma_pkg.sv
// Shared types and constants for the NASTI DMA scheduler: FSM states,
// internal completion error codes and the length alignment helper.
package nasti_dma_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    CPL       = 3'd5
  } state_e;

  // cpl_err is the OR of any non-NONE code; the code itself is kept for debug.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_REJECT  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic int unsigned align_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/nasti_dma_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, wrapping around; pointer bookkeeping belongs to the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  int pos;

  // Scan from the farthest slot toward the pointer so the nearest request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos   = (int'(ptr_i) + k) % NUM_REQ;
      idx_o = req_i[pos] ? IW'(pos) : idx_o;
      any_o = req_i[pos] | any_o;
    end
    gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/nasti_dma_scheduler.sv
// Shares one NASTI data mover between NUM_REQ requesters: round-robin grant,
// length validation, en/done sequencing and one completion per accepted job.
module nasti_dma_scheduler
  import nasti_dma_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int START_TIMEOUT = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_length,
  output logic [ADDR_WIDTH-1:0]         mv_src_addr,
  output logic [ADDR_WIDTH-1:0]         mv_dest_addr,
  output logic [ADDR_WIDTH-1:0]         mv_length,
  output logic                          mv_en,
  input  logic                          mv_done,
  output logic                          cpl_valid,
  output logic [$clog2(NUM_REQ)-1:0]    cpl_id,
  output logic                          cpl_err,
  input  logic                          cpl_ready,
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TW   = $clog2(START_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'((64'd1 << align_bits(DATA_WIDTH)) - 64'd1);

  state_e                  state_q;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         id_q;
  logic [TW-1:0]           timer_q;
  logic [1:0]              err_code_q;
  logic [NUM_REQ-1:0]      req_ready_q;
  logic [ADDR_WIDTH-1:0]   mv_src_q, mv_dest_q, mv_len_q;
  logic                    mv_en_q, cpl_valid_q, busy_q;

  logic [NUM_REQ-1:0]      gnt_s;
  logic [ID_W-1:0]         gidx_s;
  logic                    gany_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gidx_s),
    .any_o (gany_s)
  );

  assign ptr_d = (gidx_s == ID_W'(NUM_REQ - 1)) ? '0 : gidx_s + ID_W'(1);

  // Job sequencer; operands only move on the grant so the mover sees them stable.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      timer_q     <= '0;
      err_code_q  <= ERR_NONE;
      req_ready_q <= '0;
      mv_src_q    <= '0;
      mv_dest_q   <= '0;
      mv_len_q    <= '0;
      mv_en_q     <= 1'b0;
      cpl_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_ready_q <= '0;
      mv_en_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mv_done && gany_s) begin
            req_ready_q <= gnt_s;
            mv_src_q    <= req_src_addr[int'(gidx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            mv_dest_q   <= req_dest_addr[int'(gidx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            mv_len_q    <= req_length[int'(gidx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            id_q        <= gidx_s;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          if (mv_len_q == '0 || (mv_len_q & ALIGN_MASK) != '0) begin
            err_code_q  <= ERR_REJECT;
            cpl_valid_q <= 1'b1;
            state_q     <= CPL;
          end else begin
            mv_en_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT_BUSY;
        end
        // The mover must acknowledge by dropping done within START_TIMEOUT cycles.
        WAIT_BUSY: begin
          if (!mv_done) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
            err_code_q  <= ERR_TIMEOUT;
            cpl_valid_q <= 1'b1;
            state_q     <= CPL;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (mv_done) begin
            err_code_q  <= ERR_NONE;
            cpl_valid_q <= 1'b1;
            state_q     <= CPL;
          end
        end
        CPL: begin
          if (cpl_ready) begin
            cpl_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          cpl_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign mv_src_addr  = mv_src_q;
  assign mv_dest_addr = mv_dest_q;
  assign mv_length    = mv_len_q;
  assign mv_en        = mv_en_q;
  assign cpl_valid    = cpl_valid_q;
  assign cpl_id       = id_q;
  assign cpl_err      = (err_code_q != ERR_NONE);
  assign busy         = busy_q;

endmodule

// File: tb/tb_nasti_dma_scheduler.sv
// Scoreboard bench for nasti_dma_scheduler with a behavioural mover model.
module tb_nasti_dma_scheduler;

  localparam int NR = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 16;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*AW-1:0]  req_src_addr, req_dest_addr, req_length;
  logic [AW-1:0]     mv_src_addr, mv_dest_addr, mv_length;
  logic              mv_en, mv_done, cpl_valid, cpl_err, cpl_ready, busy;
  logic [1:0]        cpl_id;

  typedef struct {
    int          id;
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] len;
    logic        err;
    int          ens;
    int          lat;
  } job_t;

  job_t exp_q[$];
  job_t cur;
  logic cur_v = 1'b0;
  logic cpl_seen = 1'b0;
  int   total = 0, bad = 0;
  int   grant_cnt = 0, cpl_cnt = 0, en_cnt = 0, cyc = 0, en_cyc = 0;
  int   g_exp = 0, c_exp = 0;
  int   busy_len = 5;
  logic mv_hang = 1'b0;
  int   mv_cnt;

  nasti_dma_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_addr(req_src_addr), .req_dest_addr(req_dest_addr), .req_length(req_length),
    .mv_src_addr(mv_src_addr), .mv_dest_addr(mv_dest_addr), .mv_length(mv_length),
    .mv_en(mv_en), .mv_done(mv_done),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_err(cpl_err), .cpl_ready(cpl_ready),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Mover model: drops done the cycle after en, raises it busy_len cycles later.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mv_done <= 1'b1;
      mv_cnt  <= 0;
    end else if (mv_en && !mv_hang) begin
      mv_done <= 1'b0;
      mv_cnt  <= busy_len;
    end else if (!mv_done) begin
      if (mv_cnt <= 1) mv_done <= 1'b1;
      else mv_cnt <= mv_cnt - 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [63:0] s, input logic [63:0] d,
                      input logic [63:0] l, input logic e, input int ens, input int lat);
    job_t j;
    j.id = id; j.src = s; j.dst = d; j.len = l; j.err = e; j.ens = ens; j.lat = lat;
    exp_q.push_back(j);
    g_exp++;
    c_exp++;
  endtask

  task automatic set_job(input int i, input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
    req_src_addr[i*AW +: AW]  = s;
    req_dest_addr[i*AW +: AW] = d;
    req_length[i*AW +: AW]    = l;
    req_valid[i]              = 1'b1;
  endtask

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (grant_cnt < n && k < 3000) begin
      @(posedge aclk); #1;
      k++;
    end
    if (grant_cnt < n) check_val("grant_wait", 64'(grant_cnt), 64'(n));
  endtask

  task automatic wait_cpls(input int n);
    int k;
    k = 0;
    while (cpl_cnt < n && k < 3000) begin
      @(posedge aclk); #1;
      k++;
    end
    if (cpl_cnt < n) check_val("cpl_wait", 64'(cpl_cnt), 64'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_mv_en"}, 64'(mv_en), 64'd0);
    check_val({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check_val({tag, "_mv_src"}, mv_src_addr, 64'd0);
    check_val({tag, "_mv_dest"}, mv_dest_addr, 64'd0);
    check_val({tag, "_mv_len"}, mv_length, 64'd0);
    check_val({tag, "_cpl_valid"}, 64'(cpl_valid), 64'd0);
    check_val({tag, "_cpl_id"}, 64'(cpl_id), 64'd0);
    check_val({tag, "_cpl_err"}, 64'(cpl_err), 64'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  initial forever begin
    logic [NR-1:0] oh;
    @(negedge aclk);
    if (!aresetn) begin
      cur_v = 1'b0;
    end else begin
      if (|req_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexp_grant", 64'(req_ready), 64'd0);
        end else begin
          cur      = exp_q.pop_front();
          cur_v    = 1'b1;
          cpl_seen = 1'b0;
          en_cnt   = 0;
          grant_cnt++;
          oh = '0;
          oh[cur.id] = 1'b1;
          check_val("grant", 64'(req_ready), 64'(oh));
        end
      end
      if (mv_en) begin
        en_cnt++;
        en_cyc = cyc;
      end
      if (busy && cur_v) begin
        check_val("mv_src", mv_src_addr, cur.src);
        check_val("mv_dest", mv_dest_addr, cur.dst);
        check_val("mv_len", mv_length, cur.len);
      end
      if (cpl_valid && cur_v && !cpl_seen) begin
        cpl_seen = 1'b1;
        if (cur.lat >= 0) check_val("timeout_lat", 64'(cyc - en_cyc), 64'(cur.lat));
      end
      if (cpl_valid && cpl_ready) begin
        if (!cur_v) begin
          check_val("unexp_cpl", 64'(cpl_valid), 64'd0);
        end else begin
          check_val("cpl_id", 64'(cpl_id), 64'(cur.id));
          check_val("cpl_err", 64'(cpl_err), 64'(cur.err));
          check_val("mv_en_pulses", 64'(en_cnt), 64'(cur.ens));
          cur_v = 1'b0;
          cpl_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid     = '0;
    req_src_addr  = '0;
    req_dest_addr = '0;
    req_length    = '0;
    cpl_ready     = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Single long job on requester 2.
    busy_len = 300;
    push(2, 64'h1000, 64'h2000, 64'h800, 1'b0, 1, -1);
    set_job(2, 64'h1000, 64'h2000, 64'h800);
    wait_grants(g_exp);
    req_valid[2] = 1'b0;
    wait_cpls(c_exp);

    // Rejected lengths: zero, then not a multiple of the beat size.
    busy_len = 5;
    push(1, 64'h3000, 64'h4000, 64'h0, 1'b1, 0, -1);
    set_job(1, 64'h3000, 64'h4000, 64'h0);
    wait_grants(g_exp);
    req_valid[1] = 1'b0;
    wait_cpls(c_exp);
    push(3, 64'h5000, 64'h6000, 64'h44, 1'b1, 0, -1);
    set_job(3, 64'h5000, 64'h6000, 64'h44);
    wait_grants(g_exp);
    req_valid[3] = 1'b0;
    wait_cpls(c_exp);

    // Fairness: all four held valid across eight grants.
    busy_len = 3;
    for (int k = 0; k < 8; k++)
      push(k % NR, 64'h10000 + 64'(k % NR) * 64'h1000, 64'h20000 + 64'(k % NR) * 64'h1000,
           64'h40, 1'b0, 1, -1);
    for (int i = 0; i < NR; i++)
      set_job(i, 64'h10000 + 64'(i) * 64'h1000, 64'h20000 + 64'(i) * 64'h1000, 64'h40);
    wait_grants(g_exp);
    req_valid = '0;
    wait_cpls(c_exp);

    // Start timeout: mover ignores en; WAIT_BUSY begins one cycle after the en pulse.
    mv_hang = 1'b1;
    push(0, 64'h7000, 64'h8000, 64'h80, 1'b1, 1, TO + 1);
    set_job(0, 64'h7000, 64'h8000, 64'h80);
    wait_grants(g_exp);
    req_valid[0] = 1'b0;
    wait_cpls(c_exp);
    mv_hang = 1'b0;
    push(1, 64'h9000, 64'hA000, 64'h100, 1'b0, 1, -1);
    set_job(1, 64'h9000, 64'hA000, 64'h100);
    wait_grants(g_exp);
    req_valid[1] = 1'b0;
    wait_cpls(c_exp);

    // Completion backpressure with requester 0 waiting.
    cpl_ready = 1'b0;
    push(1, 64'hB000, 64'hC000, 64'h40, 1'b0, 1, -1);
    set_job(1, 64'hB000, 64'hC000, 64'h40);
    wait_grants(g_exp);
    req_valid[1] = 1'b0;
    for (int k = 0; k < 100 && !cpl_valid; k++) begin
      @(posedge aclk); #1;
    end
    push(0, 64'hD000, 64'hE000, 64'h80, 1'b0, 1, -1);
    set_job(0, 64'hD000, 64'hE000, 64'h80);
    for (int k = 0; k < 20; k++) begin
      @(posedge aclk); #1;
      check_val("bp_valid", 64'(cpl_valid), 64'd1);
      check_val("bp_id", 64'(cpl_id), 64'd1);
      check_val("bp_err", 64'(cpl_err), 64'd0);
      check_val("bp_req_ready", 64'(req_ready), 64'd0);
      check_val("bp_mv_en", 64'(mv_en), 64'd0);
    end
    cpl_ready = 1'b1;
    wait_grants(g_exp);
    req_valid[0] = 1'b0;
    wait_cpls(c_exp);

    // Reset in WAIT_DONE aborts the job; pointer restarts at 0.
    busy_len = 300;
    push(2, 64'hF000, 64'hF800, 64'h200, 1'b0, 1, -1);
    c_exp--;
    set_job(2, 64'hF000, 64'hF800, 64'h200);
    wait_grants(g_exp);
    req_valid[2] = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    busy_len = 4;
    push(0, 64'h100, 64'h200, 64'h40, 1'b0, 1, -1);
    push(3, 64'h300, 64'h400, 64'h40, 1'b0, 1, -1);
    set_job(0, 64'h100, 64'h200, 64'h40);
    set_job(3, 64'h300, 64'h400, 64'h40);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    wait_grants(g_exp - 1);
    req_valid[0] = 1'b0;
    wait_grants(g_exp);
    req_valid[3] = 1'b0;
    wait_cpls(c_exp);

    repeat (5) @(posedge aclk);
    #1;
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
